// File: rtl/zbus_initiator.sv
// Single-transaction bus initiator: turns a host request into a chip-select /
// strobe sequence with programmable setup, strobe and hold widths.
module zbus_initiator #(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic       req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       reg1_cs_b,
    output logic       reg2_cs_b,
    output logic       write_strobe_b,
    output logic       read_strobe_b,
    output logic [7:0] data_out,
    output logic       data_oe,
    input  logic [7:0] data_in
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    // Counter is loaded with width-1 so each phase lasts exactly its width.
    localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       write_q, write_d;
    logic       addr_q, addr_d;
    logic       req_ready_q, req_ready_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_rdata_q, rsp_rdata_d;
    logic       reg1_cs_b_q, reg1_cs_b_d;
    logic       reg2_cs_b_q, reg2_cs_b_d;
    logic       write_strobe_b_q, write_strobe_b_d;
    logic       read_strobe_b_q, read_strobe_b_d;
    logic [7:0] data_out_q, data_out_d;
    logic       data_oe_q, data_oe_d;
    logic       active;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        addr_d      = addr_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        data_out_d  = data_out_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    state_d = SETUP;
                    cnt_d   = SETUP_LOAD;
                    write_d = req_write;
                    addr_d  = req_addr;
                    if (req_write) begin
                        data_out_d = req_wdata;
                    end
                end
            end
            SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d = STROBE;
                    cnt_d   = STROBE_LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                    // Sample on the last edge the strobe is still low.
                    if (!write_q) begin
                        rsp_rdata_d = data_in;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                if (cnt_q == 4'd0) begin
                    state_d     = IDLE;
                    cnt_d       = 4'd0;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        // Bus pins are decoded from the next state so they change on the same edge.
        active           = (state_d != IDLE);
        reg1_cs_b_d      = !(active && !addr_d);
        reg2_cs_b_d      = !(active && addr_d);
        write_strobe_b_d = !((state_d == STROBE) && write_d);
        read_strobe_b_d  = !((state_d == STROBE) && !write_d);
        data_oe_d        = active && write_d;
        req_ready_d      = !active;
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state_q          <= IDLE;
            cnt_q            <= 4'd0;
            write_q          <= 1'b0;
            addr_q           <= 1'b0;
            req_ready_q      <= 1'b0;
            rsp_valid_q      <= 1'b0;
            rsp_rdata_q      <= 8'h00;
            reg1_cs_b_q      <= 1'b1;
            reg2_cs_b_q      <= 1'b1;
            write_strobe_b_q <= 1'b1;
            read_strobe_b_q  <= 1'b1;
            data_out_q       <= 8'h00;
            data_oe_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            write_q          <= write_d;
            addr_q           <= addr_d;
            req_ready_q      <= req_ready_d;
            rsp_valid_q      <= rsp_valid_d;
            rsp_rdata_q      <= rsp_rdata_d;
            reg1_cs_b_q      <= reg1_cs_b_d;
            reg2_cs_b_q      <= reg2_cs_b_d;
            write_strobe_b_q <= write_strobe_b_d;
            read_strobe_b_q  <= read_strobe_b_d;
            data_out_q       <= data_out_d;
            data_oe_q        <= data_oe_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign reg1_cs_b      = reg1_cs_b_q;
    assign reg2_cs_b      = reg2_cs_b_q;
    assign write_strobe_b = write_strobe_b_q;
    assign read_strobe_b  = read_strobe_b_q;
    assign data_out       = data_out_q;
    assign data_oe        = data_oe_q;

endmodule
